// File: rtl/matrix_keypad_scanner_if.sv
// Keypad-side signal bundle: row return lines in, column strobe and key report out.
// Latency: none, wires only.
// Backpressure: none; tecla_valida is a one-cycle pulse the consumer must take when high.
interface matrix_keypad_scanner_if;
  logic [6:0] linhas;
  logic [4:0] contador_ring;
  logic [5:0] codigo_tecla;
  logic       tecla_valida;
  logic       tecla_pressionada;

  // Scanner side: samples rows, drives strobes and key report.
  modport master (
    input  linhas,
    output contador_ring,
    output codigo_tecla,
    output tecla_valida,
    output tecla_pressionada
  );

  // Keypad/consumer side.
  modport slave (
    output linhas,
    input  contador_ring,
    input  codigo_tecla,
    input  tecla_valida,
    input  tecla_pressionada
  );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// 5x7 key matrix scanner: one-hot column ring, 2-flop row sync, press/release debounce.
// Latency: 2 sync cycles + dwell sample + DEBOUNCE_CNT high cycles before the valid pulse.
// Backpressure: none; one tecla_valida pulse per accepted press, code held until next press.
module matrix_keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  matrix_keypad_scanner_if.master  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [6:0]    sync1_q;
  logic [6:0]    linhas_s_q;
  state_t        state_q;
  logic [4:0]    ring_q;
  logic [DW-1:0] dwell_q;
  logic [BW-1:0] deb_q;
  logic [2:0]    col_q;
  logic [2:0]    row_q;
  logic [5:0]    code_q;
  logic          valid_q;
  logic          held_q;

  logic          ring_ok_d;
  logic [4:0]    ring_rot_d;
  logic [4:0]    ring_hold_d;
  logic [2:0]    col_enc_d;
  logic [2:0]    row_enc_d;
  logic [7:0]    rows_ext_d;
  logic          key_bit_d;
  logic [5:0]    code_d;

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      linhas_s_q <= '0;
    end else begin
      sync1_q    <= kp.linhas;
      linhas_s_q <= sync1_q;
    end
  end

  // Ring sanitising: any zero or multi-hot value is replaced by column 0.
  always_comb begin
    ring_ok_d   = (ring_q != 5'd0) && ((ring_q & (ring_q - 5'd1)) == 5'd0);
    ring_rot_d  = ring_ok_d ? {ring_q[3:0], ring_q[4]} : 5'b00001;
    ring_hold_d = ring_ok_d ? ring_q : 5'b00001;
  end

  // Column index of the active strobe.
  always_comb begin
    col_enc_d = 3'd0;
    case (ring_q)
      5'b00010: col_enc_d = 3'd1;
      5'b00100: col_enc_d = 3'd2;
      5'b01000: col_enc_d = 3'd3;
      5'b10000: col_enc_d = 3'd4;
      default:  col_enc_d = 3'd0;
    endcase
  end

  // Lowest asserted row wins when several rows are active on one column.
  always_comb begin
    row_enc_d = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (linhas_s_q[i]) row_enc_d = 3'(i);
    end
  end

  // Tracked key's row bit and the key code it would report.
  always_comb begin
    rows_ext_d = {1'b0, linhas_s_q};
    key_bit_d  = rows_ext_d[row_q];
    code_d     = ({3'b000, col_q} * 6'd7) + {3'b000, row_q};
  end

  // Scan / debounce FSM with registered key report.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      ring_q  <= 5'b00001;
      dwell_q <= '0;
      deb_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            if (linhas_s_q == 7'd0) begin
              ring_q <= ring_rot_d;
            end else begin
              col_q   <= col_enc_d;
              row_q   <= row_enc_d;
              deb_q   <= '0;
              ring_q  <= ring_hold_d;
              state_q <= DEBOUNCE;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
            ring_q  <= ring_hold_d;
          end
        end
        DEBOUNCE: begin
          ring_q <= ring_hold_d;
          if (!key_bit_d) begin
            // Glitch: abandon this column and move on.
            ring_q  <= ring_rot_d;
            dwell_q <= '0;
            state_q <= SCAN;
          end else if (deb_q == DEB_LAST) begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            held_q  <= 1'b1;
            state_q <= PRESSED;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        PRESSED: begin
          ring_q <= ring_hold_d;
          if (!key_bit_d) begin
            deb_q   <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          ring_q <= ring_hold_d;
          if (key_bit_d) begin
            // Release bounce: key still considered held, no new report.
            state_q <= PRESSED;
          end else if (deb_q == DEB_LAST) begin
            held_q  <= 1'b0;
            ring_q  <= ring_rot_d;
            dwell_q <= '0;
            state_q <= SCAN;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        default: begin
          ring_q  <= 5'b00001;
          state_q <= SCAN;
        end
      endcase
    end
  end

  assign kp.contador_ring     = ring_q;
  assign kp.codigo_tecla      = code_q;
  assign kp.tecla_valida      = valid_q;
  assign kp.tecla_pressionada = held_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Bench for matrix_keypad_scanner: physical keypad stimulus plus cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic clock;
  logic reset;

  matrix_keypad_scanner_if kp_if ();

  matrix_keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kp    (kp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Physical key matrix: key_rows[c] = rows closed on column c.
  logic [6:0] key_rows [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] rows_for(input logic [4:0] ring);
    logic [6:0] r;
    r = 7'd0;
    for (int c = 0; c < 5; c++) begin
      if (ring == 5'(1 << c)) r = key_rows[c];
    end
    return r;
  endfunction

  function automatic int lowest(input logic [6:0] v);
    for (int i = 0; i < 7; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Row lines follow whatever column the scanner strobes, changing on falling edges.
  initial begin
    kp_if.linhas = 7'd0;
    forever begin
      @(negedge clock);
      kp_if.linhas = rows_for(kp_if.contador_ring);
    end
  end

  // Reference model: active column as an integer, debounce as run lengths of the tracked bit.
  localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;
  int         m_mode, m_col, m_dwell, m_run, m_kcol, m_krow, m_code;
  bit         m_valid, m_held;
  logic [6:0] m_s1, m_s;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = M_SCAN; m_col = 0; m_dwell = 0; m_run = 0;
      m_kcol = 0; m_krow = 0; m_code = 0; m_valid = 0; m_held = 0;
      m_s1 = 7'd0; m_s = 7'd0;
    end else begin
      logic [6:0] s_now;
      s_now = m_s;
      m_s   = m_s1;
      m_s1  = kp_if.linhas;
      m_valid = 0;
      case (m_mode)
        M_SCAN: begin
          if (m_dwell == SCAN_DIV - 1) begin
            m_dwell = 0;
            if (s_now == 7'd0) m_col = (m_col + 1) % 5;
            else begin
              m_kcol = m_col; m_krow = lowest(s_now); m_run = 0; m_mode = M_DEB;
            end
          end else m_dwell++;
        end
        M_DEB: begin
          if (!s_now[m_krow]) begin
            m_mode = M_SCAN; m_col = (m_col + 1) % 5; m_dwell = 0;
          end else begin
            m_run++;
            if (m_run == DEBOUNCE_CNT) begin
              m_code = m_kcol * 7 + m_krow; m_valid = 1; m_held = 1; m_mode = M_HELD;
            end
          end
        end
        M_HELD: begin
          if (!s_now[m_krow]) begin
            m_run = 0; m_mode = M_REL;
          end
        end
        default: begin
          if (s_now[m_krow]) m_mode = M_HELD;
          else begin
            m_run++;
            if (m_run == DEBOUNCE_CNT) begin
              m_held = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 5; m_dwell = 0;
            end
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    check("ring",  32'(kp_if.contador_ring),     32'(1 << m_col));
    check("code",  32'(kp_if.codigo_tecla),      32'(m_code));
    check("valid", 32'(kp_if.tecla_valida),      32'(m_valid));
    check("held",  32'(kp_if.tecla_pressionada), 32'(m_held));
    if (kp_if.tecla_valida === 1'b1) pulses++;
  end

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) key_rows[c] = 7'd0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_ring",  32'(kp_if.contador_ring),     32'd1);
    check("rst_code",  32'(kp_if.codigo_tecla),      32'd0);
    check("rst_valid", 32'(kp_if.tecla_valida),      32'd0);
    check("rst_held",  32'(kp_if.tecla_pressionada), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Idle scan: one column per 4 clocks, full loop after 20.
    repeat (4) @(posedge clock);
    settle();
    check("idle_ring_4", 32'(kp_if.contador_ring), 32'b00010);
    repeat (16) @(posedge clock);
    settle();
    check("idle_ring_20", 32'(kp_if.contador_ring), 32'b00001);
    check("idle_pulses", 32'(pulses), 32'd0);

    // Key col 2 row 2.
    @(posedge clock); key_rows[2] = 7'b0000100;
    repeat (50) @(posedge clock);
    settle();
    check("k16_pulses", 32'(pulses), 32'd1);
    check("k16_code",   32'(kp_if.codigo_tecla), 32'd16);
    check("k16_held",   32'(kp_if.tecla_pressionada), 32'd1);
    @(posedge clock); key_rows[2] = 7'd0;
    repeat (10) @(posedge clock);
    settle();
    check("k16_held_rel", 32'(kp_if.tecla_pressionada), 32'd1);
    repeat (2) @(posedge clock);
    settle();
    check("k16_released", 32'(kp_if.tecla_pressionada), 32'd0);
    check("k16_ring_next", 32'(kp_if.contador_ring), 32'b01000);

    // Short glitch on col 4 row 6.
    k = 0;
    while (kp_if.contador_ring !== 5'b10000 && k < 40) begin
      @(negedge clock); k++;
    end
    check("wait_col4", 32'(kp_if.contador_ring), 32'b10000);
    @(posedge clock); key_rows[4] = 7'b1000000;
    repeat (3) @(posedge clock); key_rows[4] = 7'd0;
    repeat (3) @(posedge clock);
    settle();
    check("glitch_ring",   32'(kp_if.contador_ring), 32'b00001);
    check("glitch_code",   32'(kp_if.codigo_tecla),  32'd16);
    check("glitch_pulses", 32'(pulses), 32'd1);

    // Col 0 row 0 with bouncy release.
    @(posedge clock); key_rows[0] = 7'b0000001;
    repeat (50) @(posedge clock);
    settle();
    check("k0_pulses", 32'(pulses), 32'd2);
    check("k0_code",   32'(kp_if.codigo_tecla), 32'd0);
    check("k0_held",   32'(kp_if.tecla_pressionada), 32'd1);
    repeat (3) begin
      @(posedge clock); key_rows[0] = 7'd0;
      repeat (3) @(posedge clock); key_rows[0] = 7'b0000001;
      repeat (2) @(posedge clock);
    end
    @(posedge clock); key_rows[0] = 7'd0;
    repeat (10) @(posedge clock);
    settle();
    check("k0_held_7low", 32'(kp_if.tecla_pressionada), 32'd1);
    @(posedge clock);
    settle();
    check("k0_released", 32'(kp_if.tecla_pressionada), 32'd0);
    check("k0_pulses_end", 32'(pulses), 32'd2);

    // Rows 3 and 5 together on col 1.
    @(posedge clock); key_rows[1] = 7'b0101000;
    repeat (50) @(posedge clock);
    settle();
    check("k10_code",   32'(kp_if.codigo_tecla), 32'd10);
    check("k10_pulses", 32'(pulses), 32'd3);
    @(posedge clock); key_rows[1] = 7'd0;
    repeat (20) @(posedge clock);
    settle();
    check("k10_released", 32'(kp_if.tecla_pressionada), 32'd0);

    // Reset while col 3 row 1 is held.
    @(posedge clock); key_rows[3] = 7'b0000010;
    repeat (60) @(posedge clock);
    settle();
    check("k22_code",   32'(kp_if.codigo_tecla), 32'd22);
    check("k22_pulses", 32'(pulses), 32'd4);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_ring",  32'(kp_if.contador_ring),     32'd1);
    check("arst_code",  32'(kp_if.codigo_tecla),      32'd0);
    check("arst_held",  32'(kp_if.tecla_pressionada), 32'd0);
    check("arst_valid", 32'(kp_if.tecla_valida),      32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (60) @(posedge clock);
    settle();
    check("k22_again_pulses", 32'(pulses), 32'd5);
    check("k22_again_code",   32'(kp_if.codigo_tecla), 32'd22);
    check("k22_again_held",   32'(kp_if.tecla_pressionada), 32'd1);
    @(posedge clock); key_rows[3] = 7'd0;
    repeat (20) @(posedge clock);
    settle();
    check("k22_released", 32'(kp_if.tecla_pressionada), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
